// File: rtl/cnt_report_collector_if.sv
// Host read port of the counter-report collector: request/ack address phase,
// one-cycle valid pulse carrying the table entry.
interface cnt_report_collector_if #(
    parameter int AW       = 12,
    parameter int VAL_BITS = 52
);
    logic                rd_req;
    logic [AW-1:0]       rd_addr;
    logic                rd_ack;
    logic                rd_vld;
    logic [VAL_BITS-1:0] rd_data;

    modport master (output rd_req, rd_addr, input rd_ack, rd_vld, rd_data);
    modport slave  (input rd_req, rd_addr, output rd_ack, rd_vld, rd_data);
endinterface

// File: rtl/cnt_report_collector.sv
// Counter-report sink: filters reports addressed to CNT_PORT on this leaf and stores them in a
// table indexed by {src_leaf, src_port, cnt_type}. Define CNT_COLLECT_ACCUM_EN for accumulating entries.
module cnt_report_collector #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int PAYLOAD_BITS  = 64,
    parameter int SELF_LEAF     = 0,
    parameter int CNT_PORT      = 1,
    parameter int CNT_BITS      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_BITS-1:0] stream_in,
    input  logic                   clear,
    input  logic [CNT_BITS-1:0]    expected_reports,
    cnt_report_collector_if.slave  rd,
    output logic [CNT_BITS-1:0]    report_cnt,
    output logic [CNT_BITS-1:0]    drop_cnt,
    output logic                   all_reported,
    output logic                   busy_clear
);
    localparam int VAL_BITS = PAYLOAD_BITS - 2 - NUM_LEAF_BITS - NUM_PORT_BITS;
    localparam int AW       = NUM_LEAF_BITS + NUM_PORT_BITS + 2;
    localparam int DEPTH    = 1 << AW;
    localparam logic [NUM_LEAF_BITS-1:0] SELF_ID = NUM_LEAF_BITS'(SELF_LEAF);
    localparam logic [NUM_PORT_BITS-1:0] CNT_ID  = NUM_PORT_BITS'(CNT_PORT);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            sweep_addr;
    logic [VAL_BITS-1:0]      mem [DEPTH];
    logic [VAL_BITS-1:0]      mem_q;
    logic                     mem_we, mem_re;
    logic [AW-1:0]            mem_waddr, mem_raddr;
    logic [VAL_BITS-1:0]      mem_wdata;
    logic                     wr_commit;
    logic [AW-1:0]            wr_addr;
    logic [VAL_BITS-1:0]      wr_val;
    logic                     s1_valid;
    logic [AW-1:0]            s1_addr;
    logic [VAL_BITS-1:0]      s1_val;
    logic                     rd_hold_vld;
    logic [VAL_BITS-1:0]      rd_hold;

    // Packet decode: {valid, dst_leaf, dst_port, ..., payload}
    logic                     pkt_valid;
    logic [NUM_LEAF_BITS-1:0] dst_leaf, src_leaf;
    logic [NUM_PORT_BITS-1:0] dst_port, src_port;
    logic [1:0]               cnt_type;
    logic [VAL_BITS-1:0]      pkt_val;
    logic                     pkt_match, pkt_accept, pkt_drop;
    logic                     unused_hdr;

    assign pkt_valid  = stream_in[PACKET_BITS-1];
    assign dst_leaf   = stream_in[PACKET_BITS-2 -: NUM_LEAF_BITS];
    assign dst_port   = stream_in[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign cnt_type   = stream_in[PAYLOAD_BITS-1 -: 2];
    assign src_leaf   = stream_in[PAYLOAD_BITS-3 -: NUM_LEAF_BITS];
    assign src_port   = stream_in[VAL_BITS +: NUM_PORT_BITS];
    assign pkt_val    = stream_in[VAL_BITS-1:0];
    assign unused_hdr = ^stream_in[PACKET_BITS-2-NUM_LEAF_BITS-NUM_PORT_BITS:PAYLOAD_BITS];

    assign pkt_match  = pkt_valid && (dst_leaf == SELF_ID) && (dst_port == CNT_ID);
    assign pkt_accept = pkt_match && (state_q == ST_RUN) && !clear;
    assign pkt_drop   = pkt_match && (state_q == ST_CLEAR);
    assign busy_clear = (state_q == ST_CLEAR);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        if (clear)
            state_d = ST_CLEAR;
        else if (state_q == ST_CLEAR && (&sweep_addr))
            state_d = ST_RUN;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_CLEAR;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset || clear)            sweep_addr <= '0;
        else if (state_q == ST_CLEAR)  sweep_addr <= sweep_addr + 1'b1;
    end

    // S1: register the decoded report; a clear pulse flushes it along with the sweep restart
    always_ff @(posedge clk) begin
        if (reset || clear) s1_valid <= 1'b0;
        else                s1_valid <= pkt_accept;
        s1_addr <= {src_leaf, src_port, cnt_type};
        s1_val  <= pkt_val;
    end

`ifdef CNT_COLLECT_ACCUM_EN
    logic                s2_valid, s2_fwd;
    logic [AW-1:0]       s2_addr;
    logic [VAL_BITS-1:0] s2_val, s2_fwd_val, s2_old, s2_sum;

    // The table read is one cycle late, so a same-entry S2 write is forwarded into the next S2
    assign s2_old = s2_fwd ? s2_fwd_val : mem_q;
    assign s2_sum = s2_old + s2_val;

    always_ff @(posedge clk) begin
        if (reset || clear) s2_valid <= 1'b0;
        else                s2_valid <= s1_valid;
        s2_addr    <= s1_addr;
        s2_val     <= s1_val;
        s2_fwd     <= s2_valid && (s2_addr == s1_addr);
        s2_fwd_val <= s2_sum;
    end

    assign wr_commit = s2_valid;
    assign wr_addr   = s2_addr;
    assign wr_val    = s2_sum;
    assign rd.rd_ack = rd.rd_req && (state_q == ST_RUN) && !s1_valid && !reset;
    assign mem_re    = s1_valid || rd.rd_ack;
    assign mem_raddr = s1_valid ? s1_addr : rd.rd_addr;
`else
    assign wr_commit = s1_valid;
    assign wr_addr   = s1_addr;
    assign wr_val    = s1_val;
    assign rd.rd_ack = rd.rd_req && (state_q == ST_RUN) && !reset;
    assign mem_re    = rd.rd_ack;
    assign mem_raddr = rd.rd_addr;
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_addr;
        mem_wdata = '0;
        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_commit) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_val;
        end
    end

    // NOTE: the table has no reset term so it maps onto block RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_q <= mem[mem_raddr];
    end

    // rd_data shows the RAM output during the valid pulse and a captured copy afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_hold_vld <= 1'b0;
            rd_hold     <= '0;
        end else begin
            rd_hold_vld <= rd.rd_ack;
            if (rd_hold_vld) rd_hold <= mem_q;
        end
    end

    assign rd.rd_vld  = rd_hold_vld;
    assign rd.rd_data = rd_hold_vld ? mem_q : rd_hold;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            report_cnt   <= '0;
            drop_cnt     <= '0;
            all_reported <= 1'b0;
        end else begin
            if (wr_commit && report_cnt != '1) report_cnt <= report_cnt + 1'b1;
            if (pkt_drop && drop_cnt != '1)    drop_cnt   <= drop_cnt + 1'b1;
            all_reported <= (state_q == ST_RUN) && (expected_reports != '0)
                            && (report_cnt >= expected_reports);
        end
    end
endmodule
